// File: rtl/spi_ram_slave_gen.sv
// SPI slave with internal DATA_W x MEM_DEPTH RAM: one 2-bit command frame per SS_n low period.
// Define SPI_AUTOINC_EN to keep a pointer valid and auto-increment it after each data access.
module spi_ram_slave_gen #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_EXEC, S_TX, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic [ADDR_W-1:0]   addr;
  logic                addr_ok;

  assign cmd     = rx_q[FRAME_W-1 -: 2];
  assign payload = rx_q[DATA_W-1:0];
  assign addr    = payload[ADDR_W-1:0];
  assign addr_ok = {1'b0, addr} < DEPTH_L;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_L) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = 1'b0;
    err_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_vld_d = wr_vld_q;
    rd_vld_d = rd_vld_q;
    mem_we   = 1'b0;
    if (SS_n) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RX;
          cnt_d   = '0;
        end
        S_RX: begin
          rx_d = {rx_q[FRAME_W-2:0], MOSI};
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d = S_EXEC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          state_d = S_DONE;
          case (cmd)
            2'b00: if (addr_ok) begin wr_ptr_d = addr; wr_vld_d = 1'b1; end else err_d = 1'b1;
            2'b10: if (addr_ok) begin rd_ptr_d = addr; rd_vld_d = 1'b1; end else err_d = 1'b1;
            2'b01: begin
              if (wr_vld_q) begin
                mem_we = 1'b1;
`ifdef SPI_AUTOINC_EN
                wr_ptr_d = ptr_inc(wr_ptr_q);
`else
                wr_vld_d = 1'b0;
`endif
              end else begin
                err_d = 1'b1;
              end
            end
            2'b11: begin
              if (rd_vld_q) begin
                tx_d    = mem_q[rd_ptr_q];
                state_d = S_TX;
                cnt_d   = '0;
`ifdef SPI_AUTOINC_EN
                rd_ptr_d = ptr_inc(rd_ptr_q);
`else
                rd_vld_d = 1'b0;
`endif
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
        S_TX: begin
          // One extra cycle after the last bit returns MISO to 0 before DONE.
          if (cnt_q == CNT_W'(DATA_W)) begin
            state_d = S_DONE;
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vld_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vld_q <= wr_vld_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // NOTE: the RAM has no reset; contents survive rst and are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= payload;
  end

  assign MISO = miso_q;
  assign err  = err_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/spi_ram_slave_gen.md
# spi_ram_slave_gen

Parametrised SPI-slave-plus-RAM block for the next-generation SPI memory interface. It samples MOSI on the system clock while SS_n is low and decodes one command frame per SS_n assertion. It writes or reads an internal DATA_W x MEM_DEPTH memory and serialises read data on MISO, MSB first. Compared with the current SPI slave/RAM pair, it adds generic widths and depth, explicit error reporting, out-of-range address rejection, and optional pointer auto-increment.

## Interface
- DATA_W, 8, data word width; also the frame payload width.
- ADDR_W, 8, address width; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W. It need not be a power of two.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- SS_n  input  1  slave select, active-low.
- MOSI  input  1  serial data in; one bit per clk while a frame is received.
- MISO  output  1  serial read data out; reset value 0.
- busy  output  1  high in any state other than IDLE; reset value 0.
- err  output  1  one-cycle pulse on a rejected command; reset value 0.

## Operation
- Frame: FRAME_W = 2 + DATA_W bits, MSB first, as cmd[1:0] followed by payload[DATA_W-1:0].
- Address field: payload[ADDR_W-1:0]; higher payload bits are ignored for address commands.
- Commands:
  - 00 = load wr_ptr.
  - 01 = write mem[wr_ptr] = payload.
  - 10 = load rd_ptr.
  - 11 = read mem[rd_ptr] (payload ignored).
- Pointer state: wr_ptr and rd_ptr each have a valid flag (wr_vld, rd_vld), both cleared by rst.
- States:
  - IDLE: SS_n sampled low -> RX. MOSI is not sampled on this edge.
  - RX: samples one bit per edge. After the FRAME_W-th bit -> EXEC.
  - EXEC: executes the command (see below). A successful cmd 11 -> TX; every other case -> DONE.
  - TX: drives DATA_W bits on MISO, MSB first. After DATA_W cycles -> DONE.
  - DONE: waits for SS_n high.
- EXEC actions per command:
  - Cmd 00 / 10: address >= MEM_DEPTH -> err pulse, pointer and valid flag unchanged. Otherwise load the pointer and set its valid flag.
  - Cmd 01 / 11: pointer invalid -> err pulse, no memory access. Otherwise perform the access and clear that pointer's valid flag.
- SS_n sampled high in any state -> IDLE on that edge. This aborts the frame: a partially received frame has no effect, TX stops, and MISO <= 0.
- Additional bits after FRAME_W are ignored until SS_n rises; only one command is executed per SS_n low period.
- MISO is 0 in every state except TX.
- Memory contents are not reset and are undefined until written.
- rst in any state: state -> IDLE, MISO/busy/err <= 0, wr_vld/rd_vld <= 0, bit counter <= 0. Memory is retained.

## Timing
- Edge numbering: E0 is the first edge with SS_n low; bits are sampled at E1..E(FRAME_W); EXEC executes at E(FRAME_W+1).
- Write latency: memory is updated at E(FRAME_W+1).
- err pulse: asserted after E(FRAME_W+1) for exactly one cycle.
- Read path: mem[rd_ptr] is registered into the TX shift register at E(FRAME_W+1). MISO carries bit DATA_W-1-k after edge E(FRAME_W+2+k), for k = 0..DATA_W-1.
  - Defaults (FRAME_W = 10, DATA_W = 8): MISO bits appear after E12..E19, and MISO <= 0 at E20.
- SS_n rising during TX: MISO is 0 after the edge on which SS_n is sampled high.
- busy: rises after E0; falls after the edge on which SS_n is sampled high (or on rst).

## Configuration
- SPI_AUTOINC_EN defined:
  - A successful cmd 01 or cmd 11 keeps its valid flag set.
  - The pointer used then increments, wrapping from MEM_DEPTH-1 to 0.
  - Consecutive data frames therefore access sequential addresses without reloading the address.
- SPI_AUTOINC_EN undefined:
  - The valid flag is cleared after each access and the pointer is unchanged.
  - Each data command needs its own preceding address command.

## Test plan
- Write then read back (defaults): frames 00_0x3C, 01_0xA5, 10_0x3C, 11_0x00, each in its own SS_n low period -> MISO = 1,0,1,0,0,1,0,1 after E12..E19, MISO 0 at E20, err never asserted.
- Read with no address after rst: frame 11_0x00 -> one err pulse after E11, MISO 0 throughout, state DONE.
- Abort: after 00_0x10 completes, send 01 plus 4 payload bits of 0xFF, then raise SS_n -> busy 0 on the next edge, mem[0x10] unchanged. A complete 01_0x77 then writes 0x77, since wr_vld is still set.
- Range check with MEM_DEPTH=200: frame 00_0xC8 -> err pulse, wr_vld stays 0. A following 01_0x55 -> second err pulse, no write.
- Auto-increment with SPI_AUTOINC_EN: frames 00_0xFF, 01_0x11, 01_0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap). Same sequence without the macro -> third frame gives an err pulse and mem[0x00] is unchanged.
- Reset mid-TX: assert rst during TX bit 3 -> MISO, busy and err are 0 after that edge. A following 11 frame gives an err pulse because rd_vld was cleared.
